// File: rtl/memory_unit.sv
// -----------------------------------------------------------------------------
// memory_unit
//   Small RAM (DEPTH x 8-bit words) shared between a CPU-style strobed bus and
//   a program-loader port.
//
//   CPU side (i_load_mode = 0):
//     i_reg_mem_write_n  low -> MAR loads io_bus[3:0] on the clock edge
//     i_mem_read_n       low -> io_bus driven combinationally with mem[MAR]
//     i_mem_write_n      low -> mem[MAR] <= io_bus on the clock edge
//     read + write low together is a conflict: both suppressed and the sticky
//     o_bus_error flag is set.
//
//   Loader side (i_load_mode = 1):
//     i_prog_valid/i_prog_addr/i_prog_data with o_prog_ready handshake. This is
//     a three-state FSM (IDLE -> WRITE -> ACK). o_prog_ack pulses for one cycle
//     after the write commits. o_checksum is the modulo-256 sum of the loader
//     bytes written in the current load session.
//
//   Other outputs:
//     o_mar       current address register
//     o_bus_error sticky read/write strobe conflict, cleared only by reset
//
//   Memory contents are not reset.
// -----------------------------------------------------------------------------
module memory_unit #(
    parameter int DEPTH = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    inout  wire  [7:0] io_bus,
    input  logic       i_reg_mem_write_n,
    input  logic       i_mem_read_n,
    input  logic       i_mem_write_n,
    input  logic       i_load_mode,
    input  logic       i_prog_valid,
    input  logic [3:0] i_prog_addr,
    input  logic [7:0] i_prog_data,
    output logic       o_prog_ready,
    output logic       o_prog_ack,
    output logic [7:0] o_checksum,
    output logic [3:0] o_mar,
    output logic       o_bus_error
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] mem_r [DEPTH];
    logic [3:0] mar_r;
    logic [3:0] prog_addr_r;
    logic [7:0] prog_data_r;
    logic       ack_r;
    logic [7:0] checksum_r;
    logic       bus_error_r;
    logic       load_mode_prev_r;

    logic       prog_ready_s;
    logic       accept_s;
    logic       cpu_mar_load_s;
    logic       cpu_read_s;
    logic       cpu_write_s;
    logic       cpu_conflict_s;
    logic       load_rise_s;
    logic       loader_write_s;

    // CPU strobes are decoded only outside load mode; a read/write overlap
    // cancels both actions.
    assign cpu_mar_load_s = ~i_load_mode & ~i_reg_mem_write_n;
    assign cpu_conflict_s = ~i_load_mode & ~i_mem_read_n & ~i_mem_write_n;
    assign cpu_read_s     = ~i_load_mode & ~i_mem_read_n & i_mem_write_n;
    assign cpu_write_s    = ~i_load_mode & ~i_mem_write_n & i_mem_read_n;
    assign load_rise_s    = i_load_mode & ~load_mode_prev_r;
    assign loader_write_s = (state_r == ST_WRITE);

    // The bus is released immediately when reset asserts.
    assign io_bus = (cpu_read_s && i_reset_n) ? mem_r[mar_r] : {8{1'bz}};

    assign o_prog_ready = prog_ready_s;
    assign o_prog_ack   = ack_r;
    assign o_checksum   = checksum_r;
    assign o_mar        = mar_r;
    assign o_bus_error  = bus_error_r;

    // Loader FSM next-state and handshake decode.
    always_comb begin
        state_next_s = state_r;
        prog_ready_s = 1'b0;
        accept_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                prog_ready_s = i_load_mode;
                if (i_load_mode && i_prog_valid) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_WRITE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WRITE: state_next_s = ST_ACK;
            ST_ACK:   state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Loader FSM state, captured request and ack pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= ST_IDLE;
            prog_addr_r <= 4'h0;
            prog_data_r <= 8'h00;
            ack_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ack_r   <= loader_write_s;
            if (accept_s) begin
                prog_addr_r <= i_prog_addr;
                prog_data_r <= i_prog_data;
            end else begin
                prog_addr_r <= prog_addr_r;
                prog_data_r <= prog_data_r;
            end
        end
    end

    // Session checksum: cleared on entry to load mode, accumulates each loader
    // write. If entry coincides with a loader write, that byte opens the sum.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            checksum_r       <= 8'h00;
            load_mode_prev_r <= 1'b0;
        end else begin
            load_mode_prev_r <= i_load_mode;
            if (load_rise_s) begin
                checksum_r <= loader_write_s ? prog_data_r : 8'h00;
            end else if (loader_write_s) begin
                checksum_r <= checksum_r + prog_data_r;
            end else begin
                checksum_r <= checksum_r;
            end
        end
    end

    // Address register and sticky conflict flag (CPU side only).
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            mar_r       <= 4'h0;
            bus_error_r <= 1'b0;
        end else begin
            if (cpu_mar_load_s) begin
                mar_r <= io_bus[3:0];
            end else begin
                mar_r <= mar_r;
            end
            if (cpu_conflict_s) begin
                bus_error_r <= 1'b1;
            end else begin
                bus_error_r <= bus_error_r;
            end
        end
    end

    // Memory array. A loader write finishing after load mode was dropped takes
    // priority over a same-cycle CPU write.
    always_ff @(posedge i_clk) begin
        if (loader_write_s) begin
            mem_r[prog_addr_r] <= prog_data_r;
        end else if (cpu_write_s) begin
            mem_r[mar_r] <= io_bus;
        end else begin
            mem_r[mar_r] <= mem_r[mar_r];
        end
    end

endmodule

// File: tb/tb_memory_unit.sv
// -----------------------------------------------------------------------------
// tb_memory_unit
//   Directed sequence plus randomized loader/CPU traffic for memory_unit.
//   Expected values come from a plain array/sum model of the memory, MAR and
//   session checksum. "Bus not driven by the DUT" is observed by letting the
//   bench drive a known pattern and requiring the bus to carry exactly it.
// -----------------------------------------------------------------------------
module tb_memory_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       reg_n;
    logic       read_n;
    logic       write_n;
    logic       load_mode;
    logic       valid;
    logic [3:0] paddr;
    logic [7:0] pdata;
    logic       bus_en;
    logic [7:0] bus_drv;
    wire  [7:0] io_bus;
    logic       prog_ready;
    logic       prog_ack;
    logic [7:0] checksum;
    logic [3:0] mar;
    logic       bus_error;

    int         n_cmp = 0;
    int         n_bad = 0;

    logic [7:0] ref_mem [16];
    bit         ref_known [16];
    logic [3:0] ref_mar;
    int         ref_sum;

    assign io_bus = bus_en ? bus_drv : 8'hzz;

    always #5 clk = ~clk;

    memory_unit #(.DEPTH(16)) dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n),
        .io_bus            (io_bus),
        .i_reg_mem_write_n (reg_n),
        .i_mem_read_n      (read_n),
        .i_mem_write_n     (write_n),
        .i_load_mode       (load_mode),
        .i_prog_valid      (valid),
        .i_prog_addr       (paddr),
        .i_prog_data       (pdata),
        .o_prog_ready      (prog_ready),
        .o_prog_ack        (prog_ack),
        .o_checksum        (checksum),
        .o_mar             (mar),
        .o_bus_error       (bus_error)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mar(input logic [3:0] a);
        bus_en  = 1'b1;
        bus_drv = {4'h0, a};
        reg_n   = 1'b0;
        tick();
        reg_n   = 1'b1;
        bus_en  = 1'b0;
        ref_mar = a;
        chk("mar_load", {4'h0, mar}, {4'h0, a});
    endtask

    task automatic cpu_wr(input logic [7:0] d);
        bus_en  = 1'b1;
        bus_drv = d;
        write_n = 1'b0;
        tick();
        write_n = 1'b1;
        bus_en  = 1'b0;
        ref_mem[ref_mar]   = d;
        ref_known[ref_mar] = 1'b1;
    endtask

    // Read mem[MAR], then confirm the DUT lets go of the bus after release.
    task automatic cpu_rd(input string tag);
        read_n = 1'b0;
        #1;
        if (ref_known[ref_mar]) chk(tag, io_bus, ref_mem[ref_mar]);
        read_n  = 1'b1;
        bus_en  = 1'b1;
        bus_drv = 8'h00;
        #1;
        chk({tag, "_rel"}, io_bus, 8'h00);
        bus_en = 1'b0;
    endtask

    // One loader write; latency counted as cycles after the request cycle.
    task automatic prog_wr(input logic [3:0] a, input logic [7:0] d, input bit drop);
        int lat;
        valid = 1'b1;
        paddr = a;
        pdata = d;
        #1;
        chk("rdy_idle", {7'b0, prog_ready}, 8'h01);
        tick();
        valid = 1'b0;
        if (drop) load_mode = 1'b0;
        #1;
        chk("rdy_busy", {7'b0, prog_ready}, 8'h00);
        lat = 1;
        while (prog_ack !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        chk("ack_lat", 8'(lat), 8'd2);
        ref_mem[a]   = d;
        ref_known[a] = 1'b1;
        ref_sum      = ref_sum + int'(d);
        tick();
        chk("ack_pulse", {7'b0, prog_ack}, 8'h00);
        chk("rdy_after", {7'b0, prog_ready}, {7'b0, load_mode});
    endtask

    task automatic enter_load();
        load_mode = 1'b1;
        tick();
        ref_sum = 0;
        chk("cks_clear", checksum, 8'h00);
    endtask

    initial begin
        int lat;
        logic [7:0] cks_exp;
        rst_n = 1'b0; reg_n = 1'b1; read_n = 1'b1; write_n = 1'b1;
        load_mode = 1'b0; valid = 1'b0; paddr = 4'h0; pdata = 8'h00;
        bus_en = 1'b0; bus_drv = 8'h00;
        for (int i = 0; i < 16; i++) begin
            ref_known[i] = 1'b0;
            ref_mem[i]   = 8'h00;
        end
        ref_mar = 4'h0;
        ref_sum = 0;

        // Reset state
        #2;
        chk("rst_mar", {4'h0, mar}, 8'h00);
        chk("rst_ack", {7'b0, prog_ack}, 8'h00);
        chk("rst_cks", checksum, 8'h00);
        chk("rst_err", {7'b0, bus_error}, 8'h00);
        chk("rst_rdy", {7'b0, prog_ready}, 8'h00);
        read_n = 1'b0; bus_en = 1'b1; bus_drv = 8'h00;
        #1;
        chk("rst_busz", io_bus, 8'h00);
        read_n = 1'b1; bus_en = 1'b0;
        load_mode = 1'b1;
        #1;
        chk("rst_rdy_lm", {7'b0, prog_ready}, 8'h01);
        tick();
        rst_n = 1'b1;
        tick();
        ref_sum = 0;
        chk("cks_clear0", checksum, 8'h00);

        // Directed load session with checksum wrap
        prog_wr(4'h3, 8'h2A, 1'b0);
        prog_wr(4'h4, 8'hF0, 1'b0);
        cks_exp = ref_sum[7:0];
        chk("cks_wrap", checksum, cks_exp);
        load_mode = 1'b0;
        tick();
        chk("cks_hold", checksum, cks_exp);
        chk("rdy_off", {7'b0, prog_ready}, 8'h00);

        // CPU read, MAR load during read, CPU write
        set_mar(4'h3);
        cpu_rd("rd3");
        reg_n = 1'b0; read_n = 1'b0;
        #1;
        chk("rdmar_bus", io_bus, ref_mem[3]);
        tick();
        reg_n = 1'b1; read_n = 1'b1;
        ref_mar = ref_mem[3][3:0];
        chk("rdmar_mar", {4'h0, mar}, {4'h0, ref_mar});
        set_mar(4'h5);
        cpu_wr(8'h77);
        cpu_rd("rd5");

        // Isolation: CPU strobes ignored in load mode
        enter_load();
        reg_n = 1'b0; read_n = 1'b0; write_n = 1'b0;
        bus_en = 1'b1; bus_drv = 8'h0C;
        #1;
        chk("iso_bus", io_bus, 8'h0C);
        tick();
        reg_n = 1'b1; read_n = 1'b1; write_n = 1'b1; bus_en = 1'b0;
        chk("iso_mar", {4'h0, mar}, {4'h0, ref_mar});
        chk("iso_err", {7'b0, bus_error}, 8'h00);
        load_mode = 1'b0;
        tick();
        cpu_rd("iso_rd5");

        // Read/write conflict
        bus_en = 1'b1; bus_drv = 8'h11; read_n = 1'b0; write_n = 1'b0;
        #1;
        chk("cf_bus", io_bus, 8'h11);
        tick();
        read_n = 1'b1; write_n = 1'b1; bus_en = 1'b0;
        chk("cf_err", {7'b0, bus_error}, 8'h01);
        cpu_rd("cf_rd5");
        tick(); tick();
        chk("cf_sticky", {7'b0, bus_error}, 8'h01);

        // Reset while in ACK
        enter_load();
        valid = 1'b1; paddr = 4'h7; pdata = 8'h55;
        tick();
        valid = 1'b0;
        lat = 1;
        while (prog_ack !== 1'b1 && lat < 8) begin
            tick();
            lat++;
        end
        chk("mid_ack", {7'b0, prog_ack}, 8'h01);
        ref_mem[7] = 8'h55; ref_known[7] = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("mid_ack0", {7'b0, prog_ack}, 8'h00);
        chk("mid_cks0", checksum, 8'h00);
        chk("mid_err0", {7'b0, bus_error}, 8'h00);
        chk("mid_mar0", {4'h0, mar}, 8'h00);
        chk("mid_rdy", {7'b0, prog_ready}, 8'h01);
        ref_mar = 4'h0;
        tick();
        rst_n = 1'b1; load_mode = 1'b0;
        tick();
        set_mar(4'h3);
        cpu_rd("keep3");
        set_mar(4'h7);
        cpu_rd("keep7");

        // Load mode dropped during WRITE: transaction still completes
        enter_load();
        prog_wr(4'h9, 8'($urandom), 1'b1);
        cks_exp = ref_sum[7:0];
        chk("drop_cks", checksum, cks_exp);
        set_mar(4'h9);
        cpu_rd("drop_rd9");

        // Randomized load session covering every word
        enter_load();
        for (int a = 0; a < 16; a++) prog_wr(4'(a), 8'($urandom), 1'b0);
        for (int k = 0; k < 4; k++) prog_wr(4'($urandom_range(15)), 8'($urandom), 1'b0);
        cks_exp = ref_sum[7:0];
        chk("rnd_cks", checksum, cks_exp);
        load_mode = 1'b0;
        tick();
        chk("rnd_cks_hold", checksum, cks_exp);

        // Randomized CPU traffic
        for (int k = 0; k < 24; k++) begin
            set_mar(4'($urandom_range(15)));
            if ($urandom_range(1) == 1) cpu_wr(8'($urandom));
            cpu_rd("rnd_rd");
        end
        chk("end_err", {7'b0, bus_error}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
